mem_line_responder: RTL and testbench

MEM_LINE_RESPONDER -- requirements
Module: mem_line_responder

---
 rtl/mem_line_pkg.sv | 17 +
 rtl/line_pack.sv | 25 ++
 rtl/mem_line_responder.sv | 97 +++++++++
 tb/tb_mem_line_responder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mem_line_pkg.sv
// Shared types and line geometry for the memory-line responder and the cache
// controllers that talk to it.
package mem_line_pkg;
  localparam int LINE_W  = 128;
  localparam int BEAT_W  = 32;
  localparam int BEATS   = 4;
  localparam int LINE_AW = 28;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    XFER,
    CAPT,
    DONE,
    COOL
  } state_e;
endpackage

// File: rtl/line_pack.sv
// Read-line assembly: drops one 32-bit beat into its lane of the 128-bit line,
// leaving the other lanes untouched.
module line_pack
  import mem_line_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [1:0]        beat,
  input  logic [BEAT_W-1:0] din,
  output logic [LINE_W-1:0] line
);
  logic [BEATS-1:0][BEAT_W-1:0] lanes;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes <= '0;
    end else begin
      for (int i = 0; i < BEATS; i++)
        if (wr_en && beat == 2'(i)) lanes[i] <= din;
    end
  end

  assign line = lanes;
endmodule

// File: rtl/mem_line_responder.sv
// Serves 128-bit line reads/writes from a 32-bit single-port SRAM: fixed wait,
// four beats, then a one-cycle ready pulse and a one-cycle cool-down.
module mem_line_responder
  import mem_line_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int SRAM_AW = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [LINE_AW-1:0] mem_addr,
  input  logic [LINE_W-1:0]  mem_wdata,
  output logic [LINE_W-1:0]  mem_rdata,
  output logic               mem_ready,
  output logic               sram_cen,
  output logic               sram_wen,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [BEAT_W-1:0]  sram_wdata,
  input  logic [BEAT_W-1:0]  sram_rdata
);
  localparam int LA_W = SRAM_AW - 2;

  state_e                       state, nxt;
  logic [3:0]                   cnt;
  logic [1:0]                   beat;
  logic                         req_wr;
  logic [LA_W-1:0]              line_addr;
  logic [BEATS-1:0][BEAT_W-1:0] wdata;
  logic                         cap_vld;
  logic [1:0]                   cap_beat;
  logic                         req;
  logic                         unused_addr;

  assign req         = mem_read | mem_write;
  // Line-address bits above the SRAM's reach are don't-care.
  assign unused_addr = ^mem_addr[LINE_AW-1:LA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      beat      <= '0;
      req_wr    <= 1'b0;
      line_addr <= '0;
      wdata     <= '0;
      cap_vld   <= 1'b0;
      cap_beat  <= '0;
    end else begin
      state    <= nxt;
      // Read data lags the enable by one cycle, so capture trails issue.
      cap_vld  <= (state == XFER) && !req_wr;
      cap_beat <= beat;
      case (state)
        IDLE: if (req) begin
          req_wr    <= mem_write;
          line_addr <= mem_addr[LA_W-1:0];
          if (mem_write) wdata <= mem_wdata;
          cnt  <= 4'(LATENCY - 1);
          beat <= '0;
        end
        WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
        XFER: beat <= beat + 2'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (req) nxt = WAIT;
      WAIT:    if (cnt == 4'd0) nxt = XFER;
      XFER:    if (beat == 2'd3) nxt = req_wr ? DONE : CAPT;
      CAPT:    nxt = DONE;
      DONE:    nxt = COOL;
      COOL:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign sram_cen   = (state == XFER);
  assign sram_wen   = (state == XFER) && req_wr;
  assign sram_addr  = (state == XFER) ? {line_addr, beat} : '0;
  assign sram_wdata = sram_wen ? wdata[beat] : '0;
  assign mem_ready  = (state == DONE);

  line_pack u_pack (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (cap_vld),
    .beat  (cap_beat),
    .din   (sram_rdata),
    .line  (mem_rdata)
  );
endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench: two responders (LATENCY 4 and 1) each backed by a simple
// 4K x 32 SRAM model.
module tb_mem_line_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mem_read  [2] = '{1'b0, 1'b0};
  logic        mem_write [2] = '{1'b0, 1'b0};
  logic [27:0] mem_addr  [2] = '{28'h0, 28'h0};
  logic [127:0] mem_wdata[2] = '{128'h0, 128'h0};
  logic [127:0] mem_rdata[2];
  logic        mem_ready [2];
  logic        sram_cen  [2];
  logic        sram_wen  [2];
  logic [11:0] sram_addr [2];
  logic [31:0] sram_wdata[2];
  logic [31:0] sram_rdata[2];

  logic [31:0] sram [2][4096] = '{default: '0};
  int          wr_cnt [2] = '{0, 0};
  int          acc_cnt[2] = '{0, 0};

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_line_responder #(.LATENCY(4), .SRAM_AW(12)) u_l4 (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
    .mem_ready(mem_ready[0]), .sram_cen(sram_cen[0]), .sram_wen(sram_wen[0]),
    .sram_addr(sram_addr[0]), .sram_wdata(sram_wdata[0]), .sram_rdata(sram_rdata[0])
  );

  mem_line_responder #(.LATENCY(1), .SRAM_AW(12)) u_l1 (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
    .mem_ready(mem_ready[1]), .sram_cen(sram_cen[1]), .sram_wen(sram_wen[1]),
    .sram_addr(sram_addr[1]), .sram_wdata(sram_wdata[1]), .sram_rdata(sram_rdata[1])
  );

  for (genvar d = 0; d < 2; d++) begin : g_sram
    always @(posedge clk) begin
      if (sram_cen[d]) begin
        acc_cnt[d] <= acc_cnt[d] + 1;
        if (sram_wen[d]) begin
          sram[d][sram_addr[d]] <= sram_wdata[d];
          wr_cnt[d] <= wr_cnt[d] + 1;
        end else begin
          sram_rdata[d] <= sram[d][sram_addr[d]];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request; E0 is the first rising edge after driving. rdy_at is the
  // edge index after which mem_ready was seen; after is mem_ready one cycle later.
  task automatic xact(input int d, input bit rd, input bit wr, input logic [27:0] a,
                      input logic [127:0] wd, input int hold,
                      output int rdy_at, output logic after);
    @(negedge clk);
    mem_read[d] = rd; mem_write[d] = wr; mem_addr[d] = a; mem_wdata[d] = wd;
    @(posedge clk); #1;
    mem_addr[d] = ~a; mem_wdata[d] = ~wd;
    rdy_at = -1;
    for (int k = 0; k < 60; k++) begin
      if (mem_ready[d]) begin rdy_at = k; break; end
      @(posedge clk); #1;
    end
    if (hold == 0) begin mem_read[d] = 1'b0; mem_write[d] = 1'b0; end
    @(posedge clk); #1;
    after = mem_ready[d];
    if (hold > 0) begin
      repeat (hold - 1) begin @(posedge clk); #1; end
      mem_read[d] = 1'b0; mem_write[d] = 1'b0;
    end
  endtask

  task automatic window(input int d, input int n, output int pulses, output int acc);
    int a0;
    a0 = acc_cnt[d];
    pulses = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (mem_ready[d]) pulses++;
    end
    acc = acc_cnt[d] - a0;
  endtask

  initial begin
    int rdy, pulses, acc, w0, k;
    logic after;
    logic [127:0] prev;

    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset_outs", {mem_ready[d], sram_cen[d], sram_wen[d], sram_addr[d], sram_wdata[d]}, '0);
      check("reset_rdata", mem_rdata[d], '0);
    end
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("reset_held_outs", {mem_ready[0], sram_cen[0], sram_addr[0], mem_rdata[0]}, '0);
    rst_n = 1'b1;
    window(0, 20, pulses, acc);
    check("idle_ready", pulses, 0);
    check("idle_cen", acc, 0);
    check("idle_cen_l1", acc_cnt[1], 0);

    // Write then read at LATENCY=4.
    w0 = wr_cnt[0];
    xact(0, 0, 1, 28'h0000010, 128'h44444444_33333333_22222222_11111111, 0, rdy, after);
    check("wr_ready_edge", rdy, 8);
    check("wr_ready_width", after, 1'b0);
    check("wr_beats", wr_cnt[0] - w0, 4);
    check("wr_sram", {sram[0][12'h43], sram[0][12'h42], sram[0][12'h41], sram[0][12'h40]},
          128'h44444444_33333333_22222222_11111111);
    window(0, 4, pulses, acc);
    check("wr_no_extra", pulses, 0);
    xact(0, 1, 0, 28'h0000010, 128'h0, 0, rdy, after);
    check("rd_ready_edge", rdy, 9);
    check("rd_ready_width", after, 1'b0);
    check("rd_data", mem_rdata[0], 128'h44444444_33333333_22222222_11111111);
    window(0, 4, pulses, acc);

    // Read and write together: write wins, no capture.
    prev = mem_rdata[0];
    w0 = wr_cnt[0];
    xact(0, 1, 1, 28'h5, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 0, rdy, after);
    check("both_ready_edge", rdy, 8);
    check("both_wbeats", wr_cnt[0] - w0, 4);
    check("both_sram", {sram[0][23], sram[0][22], sram[0][21], sram[0][20]},
          128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A);
    check("both_rdata_kept", mem_rdata[0], 128'h44444444_33333333_22222222_11111111);
    window(0, 4, pulses, acc);

    // Request held past ready: cool-down blocks a retrigger.
    xact(0, 1, 0, 28'h5, 128'h0, 2, rdy, after);
    check("hold_ready_edge", rdy, 9);
    check("hold_ready_width", after, 1'b0);
    check("hold_rdata", mem_rdata[0], 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A);
    window(0, 20, pulses, acc);
    check("hold_no_retrigger", pulses, 0);
    check("hold_no_access", acc, 0);

    // Reset mid-write after beat 1.
    w0 = wr_cnt[0];
    @(negedge clk);
    mem_write[0] = 1'b1; mem_addr[0] = 28'h0;
    mem_wdata[0] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    k = 0;
    while (wr_cnt[0] - w0 < 2 && k < 40) begin @(posedge clk); #1; k++; end
    check("rst_reached_beat1", wr_cnt[0] - w0, 2);
    rst_n = 1'b0;
    #1;
    check("rst_async_outs", {mem_ready[0], sram_cen[0], sram_wen[0], sram_addr[0], sram_wdata[0]}, '0);
    check("rst_async_rdata", mem_rdata[0], '0);
    mem_write[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wbeats", wr_cnt[0] - w0, 2);
    check("rst_partial", {sram[0][3], sram[0][2], sram[0][1], sram[0][0]},
          128'h00000000_00000000_BBBBBBBB_AAAAAAAA);
    @(negedge clk);
    rst_n = 1'b1;
    xact(0, 1, 0, 28'h0, 128'h0, 0, rdy, after);
    check("post_rst_ready_edge", rdy, 9);
    check("post_rst_rdata", mem_rdata[0], 128'h00000000_00000000_BBBBBBBB_AAAAAAAA);
    window(0, 4, pulses, acc);

    // LATENCY=1, top line of the SRAM.
    w0 = wr_cnt[1];
    xact(1, 0, 1, 28'h00003FF, 128'h89ABCDEF_01234567_FEDCBA98_76543210, 0, rdy, after);
    check("l1_wr_ready_edge", rdy, 5);
    check("l1_wbeats", wr_cnt[1] - w0, 4);
    check("l1_top_sram", {sram[1][12'hFFF], sram[1][12'hFFE], sram[1][12'hFFD], sram[1][12'hFFC]},
          128'h89ABCDEF_01234567_FEDCBA98_76543210);
    check("l1_no_wrap", {sram[1][3], sram[1][2], sram[1][1], sram[1][0]}, '0);
    window(1, 4, pulses, acc);
    xact(1, 1, 0, 28'h00003FF, 128'h0, 0, rdy, after);
    check("l1_rd_ready_edge", rdy, 6);
    check("l1_rd_ready_width", after, 1'b0);
    check("l1_rdata", mem_rdata[1], 128'h89ABCDEF_01234567_FEDCBA98_76543210);
    window(1, 4, pulses, acc);
    check("l1_no_extra", pulses, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
